// File: rtl/regfile_exec_pkg.sv
// regfile_exec_pkg
//   Shared definitions for the Simple RISC instruction sequencer:
//   opcode/op constants, shift codes, FSM state encoding, ALU function
//   codes and the instruction field bit positions.
package regfile_exec_pkg;

   localparam int DATA_W = 16;
   localparam int IMM8_W = 8;

   // Instruction field positions
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int OP_HI  = 12;
   localparam int OP_LO  = 11;
   localparam int RN_HI  = 10;
   localparam int RN_LO  = 8;
   localparam int RD_HI  = 7;
   localparam int RD_LO  = 5;
   localparam int SH_HI  = 4;
   localparam int SH_LO  = 3;
   localparam int RM_HI  = 2;
   localparam int RM_LO  = 0;

   // Opcode classes
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   // op field within OPC_MOV
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;

   // op field within OPC_ALU
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CMP = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MVN = 2'b11;

   // Shift codes applied to operand B
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL1 = 2'b01;
   localparam logic [1:0] SH_LSR1 = 2'b10;
   localparam logic [1:0] SH_ASR1 = 2'b11;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GET_A  = 3'd2,
      S_GET_B  = 3'd3,
      S_ALU    = 3'd4,
      S_WRITE  = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      FN_ADD  = 3'd0,
      FN_SUB  = 3'd1,
      FN_AND  = 3'd2,
      FN_NOT  = 3'd3,
      FN_PASS = 3'd4
   } alu_fn_t;

endpackage

// File: rtl/exec_alu.sv
// exec_alu
//   Combinational shifter + ALU. Operand B is shifted first, then combined
//   with A. Status is always derived from A - shifted B so the sequencer
//   only has to decide when to latch it.
// Ports:
//   i_a      in  16  operand A
//   i_b      in  16  operand B (pre-shift)
//   i_sh     in  2   shift code for B
//   i_fn     in  3   alu_fn_t function select
//   o_y      out 16  result
//   o_status out 3   {V,N,Z} of A - shifted B
module exec_alu
   import regfile_exec_pkg::*;
(
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic [1:0]  i_sh,
   input  logic [2:0]  i_fn,
   output logic [15:0] o_y,
   output logic [2:0]  o_status
);

   logic [15:0] w_bsh;
   logic [15:0] w_diff;
   logic        w_v;

   always_comb begin
      w_bsh = i_b;
      case (i_sh)
         SH_LSL1: w_bsh = {i_b[14:0], 1'b0};
         SH_LSR1: w_bsh = {1'b0, i_b[15:1]};
         SH_ASR1: w_bsh = {i_b[15], i_b[15:1]};
         default: w_bsh = i_b;
      endcase
   end

   assign w_diff = i_a - w_bsh;
   // Subtraction overflows when operand signs differ and the result sign
   // does not match A.
   assign w_v    = (i_a[15] ^ w_bsh[15]) & (w_diff[15] ^ i_a[15]);
   assign o_status = {w_v, w_diff[15], (w_diff == 16'd0)};

   always_comb begin
      o_y = 16'd0;
      case (alu_fn_t'(i_fn))
         FN_ADD:  o_y = i_a + w_bsh;
         FN_SUB:  o_y = w_diff;
         FN_AND:  o_y = i_a & w_bsh;
         FN_NOT:  o_y = ~w_bsh;
         FN_PASS: o_y = w_bsh;
         default: o_y = 16'd0;
      endcase
   end

endmodule

// File: rtl/regfile_exec_ctrl.sv
// regfile_exec_ctrl
//   Instruction sequencer and datapath around an 8x16 regfile. One
//   instruction is accepted per start handshake (start sampled only while
//   ready=1, instr captured on that edge), operands are read into A/B,
//   exec_alu computes C, and the result is written back.
//   Optional feature macro: EXEC_ILLEGAL_TRAP_EN (undefined opcode traps
//   until reset instead of acting as a NOP).
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start, instr            request handshake and instruction
//   ready                   1 iff in WAIT
//   rf_rdata                regfile combinational read data
//   rf_readnum              regfile read select
//   rf_writenum, rf_write,
//   rf_wdata                regfile write port
//   result                  C register
//   status                  {V,N,Z}
//   illegal                 trap flag
module regfile_exec_ctrl
   import regfile_exec_pkg::*;
#(
   parameter int W     = 16,
   parameter int IMM_W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [15:0]  instr,
   output logic         ready,
   input  logic [W-1:0] rf_rdata,
   output logic [2:0]   rf_readnum,
   output logic [2:0]   rf_writenum,
   output logic         rf_write,
   output logic [W-1:0] rf_wdata,
   output logic [W-1:0] result,
   output logic [2:0]   status,
   output logic         illegal
);

   state_t      r_state, w_next;
   logic [15:0] r_instr;
   logic [15:0] r_a, r_b, r_c;
   logic [2:0]  r_status;

   logic [2:0]  w_opc, w_rn, w_rd, w_rm;
   logic [1:0]  w_op, w_sh;
   logic        w_mov_imm, w_mov_reg, w_is_alu, w_is_cmp, w_needs_a, w_legal;
   alu_fn_t     w_fn;
   logic [15:0] w_alu_y;
   logic [2:0]  w_alu_status;
   logic [15:0] w_imm_ext;

   assign w_opc = r_instr[OPC_HI:OPC_LO];
   assign w_op  = r_instr[OP_HI:OP_LO];
   assign w_rn  = r_instr[RN_HI:RN_LO];
   assign w_rd  = r_instr[RD_HI:RD_LO];
   assign w_sh  = r_instr[SH_HI:SH_LO];
   assign w_rm  = r_instr[RM_HI:RM_LO];

   assign w_mov_imm = (w_opc == OPC_MOV) && (w_op == OP_MOV_IMM);
   assign w_mov_reg = (w_opc == OPC_MOV) && (w_op == OP_MOV_REG);
   assign w_is_alu  = (w_opc == OPC_ALU);
   assign w_is_cmp  = w_is_alu && (w_op == OP_CMP);
   // ADD, CMP and AND read Rn; MVN and MOV reg only read Rm.
   assign w_needs_a = w_is_alu && (w_op != OP_MVN);
   assign w_legal   = w_mov_imm | w_mov_reg | w_is_alu;
   assign w_imm_ext = {{(W-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};

   always_comb begin
      w_fn = FN_PASS;
      if (w_is_alu) begin
         case (w_op)
            OP_ADD:  w_fn = FN_ADD;
            OP_CMP:  w_fn = FN_SUB;
            OP_AND:  w_fn = FN_AND;
            default: w_fn = FN_NOT;
         endcase
      end
   end

   exec_alu u_alu (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_sh     (w_sh),
      .i_fn     (w_fn),
      .o_y      (w_alu_y),
      .o_status (w_alu_status)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_WAIT;
      else          r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_WAIT:   if (start) w_next = S_DECODE;
         S_DECODE: begin
            if (w_mov_imm)      w_next = S_WRITE;
            else if (w_needs_a) w_next = S_GET_A;
            else if (w_legal)   w_next = S_GET_B;
            else begin
`ifdef EXEC_ILLEGAL_TRAP_EN
               w_next = S_TRAP;
`else
               w_next = S_WAIT;
`endif
            end
         end
         S_GET_A:  w_next = S_GET_B;
         S_GET_B:  w_next = S_ALU;
         S_ALU:    w_next = w_is_cmp ? S_WAIT : S_WRITE;
         S_WRITE:  w_next = S_WAIT;
`ifdef EXEC_ILLEGAL_TRAP_EN
         S_TRAP:   w_next = S_TRAP;
`endif
         default:  w_next = S_WAIT;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_instr  <= 16'd0;
         r_a      <= 16'd0;
         r_b      <= 16'd0;
         r_c      <= 16'd0;
         r_status <= 3'd0;
      end else begin
         if (r_state == S_WAIT && start) r_instr <= instr;
         if (r_state == S_GET_A) r_a <= rf_rdata;
         if (r_state == S_GET_B) r_b <= rf_rdata;
         if (r_state == S_ALU) begin
            if (w_is_cmp) r_status <= w_alu_status;
            else          r_c      <= w_alu_y;
         end
      end
   end

   // Output logic
   always_comb begin
      ready       = (r_state == S_WAIT);
      rf_readnum  = 3'd0;
      rf_writenum = 3'd0;
      rf_write    = 1'b0;
      rf_wdata    = '0;
      illegal     = 1'b0;
      case (r_state)
         S_GET_A: rf_readnum = w_rn;
         S_GET_B: rf_readnum = w_rm;
         S_WRITE: begin
            rf_write    = 1'b1;
            rf_writenum = w_mov_imm ? w_rn : w_rd;
            rf_wdata    = w_mov_imm ? w_imm_ext : r_c;
         end
         default: ;
      endcase
`ifdef EXEC_ILLEGAL_TRAP_EN
      illegal = (r_state == S_TRAP);
`endif
   end

   assign result = r_c;
   assign status = r_status;

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// tb_regfile_exec_ctrl
//   Drives regfile_exec_ctrl against a behavioural 8x16 regfile, applies a
//   table of instructions with hand-computed latency / write / status
//   expectations, then covers reset mid-instruction and undefined opcodes.
module tb_regfile_exec_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] instr;
   logic        ready;
   logic [15:0] rf_rdata;
   logic [2:0]  rf_readnum;
   logic [2:0]  rf_writenum;
   logic        rf_write;
   logic [15:0] rf_wdata;
   logic [15:0] result;
   logic [2:0]  status;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_exec_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .instr       (instr),
      .ready       (ready),
      .rf_rdata    (rf_rdata),
      .rf_readnum  (rf_readnum),
      .rf_writenum (rf_writenum),
      .rf_write    (rf_write),
      .rf_wdata    (rf_wdata),
      .result      (result),
      .status      (status),
      .illegal     (illegal)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Regfile model: combinational read, write on rising edge, not reset
   logic [15:0] rf [8];
   initial for (int i = 0; i < 8; i++) rf[i] = 16'd0;
   assign rf_rdata = rf[rf_readnum];
   always @(posedge clk) if (rf_write) rf[rf_writenum] <= rf_wdata;

   // Write-port monitor, sampled away from the active edge
   int          wr_cnt = 0;
   logic [2:0]  last_wnum;
   logic [15:0] last_wdata;
   always @(negedge clk) begin
      if (rf_write) begin
         wr_cnt     = wr_cnt + 1;
         last_wnum  = rf_writenum;
         last_wdata = rf_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one instruction and count edges from the accepting edge until
   // ready is seen again (bounded).
   task automatic run_instr(input logic [15:0] ins, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      instr = ins;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!ready && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   typedef struct {
      logic [15:0] ins;
      int          lat;
      int          writes;
      logic [2:0]  wnum;
      logic [15:0] wdata;
      logic [2:0]  stat;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   initial begin
      int lat;
      int wb;

      // Expected values: latency in edges, number of rf_write pulses,
      // write target/data, {V,N,Z} after the instruction.
      vecs[0]  = '{16'hD0FD, 3, 1, 3'd0, 16'hFFFD, 3'b000}; // MOV R0,#-3
      vecs[1]  = '{16'hD107, 3, 1, 3'd1, 16'h0007, 3'b000}; // MOV R1,#7
      vecs[2]  = '{16'hD202, 3, 1, 3'd2, 16'h0002, 3'b000}; // MOV R2,#2
      vecs[3]  = '{16'hA16A, 6, 1, 3'd3, 16'h000B, 3'b000}; // ADD R3,R1,R2,LSL1
      vecs[4]  = '{16'hD1FF, 3, 1, 3'd1, 16'hFFFF, 3'b000}; // MOV R1,#-1
      vecs[5]  = '{16'hC031, 5, 1, 3'd1, 16'h7FFF, 3'b000}; // MOV R1,R1,LSR1
      vecs[6]  = '{16'hD2FF, 3, 1, 3'd2, 16'hFFFF, 3'b000}; // MOV R2,#-1
      vecs[7]  = '{16'hA902, 5, 0, 3'd0, 16'h0000, 3'b110}; // CMP R1,R2
      vecs[8]  = '{16'hD601, 3, 1, 3'd6, 16'h0001, 3'b110}; // MOV R6,#1
      vecs[9]  = '{16'hD07F, 3, 1, 3'd0, 16'h007F, 3'b110}; // MOV R0,#0x7F
      vecs[10] = '{16'hA000, 6, 1, 3'd0, 16'h00FE, 3'b110}; // ADD R0,R0,R0
      vecs[11] = '{16'hA006, 6, 1, 3'd0, 16'h00FF, 3'b110}; // ADD R0,R0,R6
      vecs[12] = '{16'hB880, 5, 1, 3'd4, 16'hFF00, 3'b110}; // MVN R4,R0
      vecs[13] = '{16'hD0FA, 3, 1, 3'd0, 16'hFFFA, 3'b110}; // MOV R0,#-6
      vecs[14] = '{16'hB810, 5, 1, 3'd0, 16'h8002, 3'b110}; // MVN R0,R0,LSR1
      vecs[15] = '{16'hC0B8, 5, 1, 3'd5, 16'hC001, 3'b110}; // MOV R5,R0,ASR1
      vecs[16] = '{16'hB4E5, 6, 1, 3'd7, 16'hC000, 3'b110}; // AND R7,R4,R5
      vecs[17] = '{16'hAC04, 5, 0, 3'd0, 16'h0000, 3'b001}; // CMP R4,R4
      vecs[18] = '{16'hAD04, 5, 0, 3'd0, 16'h0000, 3'b010}; // CMP R5,R4

      // Reset
      reset_n = 1'b0;
      start   = 1'b0;
      instr   = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready",   ready,      1);
      check("reset_result",  result,     0);
      check("reset_status",  status,     0);
      check("reset_rf_write", rf_write,  0);
      check("reset_readnum", rf_readnum, 0);
      check("reset_illegal", illegal,    0);
      @(negedge clk);
      reset_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         wb = wr_cnt;
         run_instr(vecs[i].ins, lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_writes", i), wr_cnt - wb, vecs[i].writes);
         if (vecs[i].writes > 0) begin
            check($sformatf("v%0d_wnum", i),  last_wnum,  vecs[i].wdata === 16'hx ? 0 : vecs[i].wnum);
            check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wdata);
         end
         check($sformatf("v%0d_status", i),  status,  vecs[i].stat);
         check($sformatf("v%0d_illegal", i), illegal, 0);
      end
      check("result_after_and", result, 16'hC000);
      check("rf_r3", rf[3], 16'h000B);
      check("rf_r7", rf[7], 16'hC000);

      // Reset asserted while an ADD sits in GET_B
      wb = wr_cnt;
      @(negedge clk);
      instr = 16'hA16A;
      start = 1'b1;
      @(posedge clk);          // accept -> DECODE
      #1 start = 1'b0;
      @(posedge clk);          // -> GET_A
      @(posedge clk);          // -> GET_B
      #1;
      check("mid_readnum_getb", rf_readnum, 3'd2);
      reset_n = 1'b0;
      #1;
      check("mid_reset_ready",    ready,    1);
      check("mid_reset_rf_write", rf_write, 0);
      check("mid_reset_result",   result,   0);
      check("mid_reset_status",   status,   0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("mid_reset_no_write", wr_cnt - wb, 0);
      check("mid_reset_r3_kept",  rf[3], 16'h000B);
      check("mid_reset_idle",     ready, 1);

      // Undefined instruction 0x0000
`ifdef EXEC_ILLEGAL_TRAP_EN
      wb = wr_cnt;
      @(negedge clk);
      instr = 16'h0000;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("trap_illegal",  illegal,  1);
      check("trap_ready",    ready,    0);
      check("trap_rf_write", rf_write, 0);
      check("trap_no_write", wr_cnt - wb, 0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("trap_reset_illegal", illegal, 0);
      check("trap_reset_ready",   ready,   1);
      @(negedge clk);
      reset_n = 1'b1;
`else
      wb = wr_cnt;
      run_instr(16'h0000, lat);
      check("nop_latency",  lat,         2);
      check("nop_writes",   wr_cnt - wb, 0);
      check("nop_illegal",  illegal,     0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
